// File: rtl/uart_rx_arbiter_pkg.sv
// rtl/uart_rx_arbiter_pkg.sv - shared types and defaults for the uart rx arbiter
package uart_rx_arbiter_pkg;

    localparam int DEFAULT_NUM_CH         = 4;
    localparam int DEFAULT_DATA_BIT_COUNT = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_rx_arbiter_capture.sv
// rtl/uart_rx_arbiter_capture.sv - per-channel edge detect, one-byte hold and overrun flag
module rx_capture #(
    parameter int DATA_BIT_COUNT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_ready,
    input  logic [DATA_BIT_COUNT-1:0] rx_data,
    input  logic                      take,
    output logic                      pending,
    output logic [DATA_BIT_COUNT-1:0] hold,
    output logic                      overrun,
    input  logic                      overrun_clr
);

    logic rx_prev;
    logic capture;

    assign capture = rx_ready && !rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Starts high so a ready level already asserted at reset is ignored.
            rx_prev <= 1'b1;
            pending <= 1'b0;
            hold    <= '0;
            overrun <= 1'b0;
        end else begin
            rx_prev <= rx_ready;
            // A grant in the same cycle frees the slot, so the new byte still fits.
            if (capture && (!pending || take)) begin
                hold    <= rx_data;
                pending <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end
            if (capture && pending && !take) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_rx_arbiter.sv
// rtl/uart_rx_arbiter.sv - round-robin merge of uart_rx byte streams into one tagged stream
module uart_rx_arbiter
    import uart_rx_arbiter_pkg::*;
#(
    parameter int NUM_CH         = DEFAULT_NUM_CH,
    parameter int DATA_BIT_COUNT = DEFAULT_DATA_BIT_COUNT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                rx_ready,
    input  logic [NUM_CH*DATA_BIT_COUNT-1:0] rx_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_BIT_COUNT-1:0]        out_data,
    output logic [$clog2(NUM_CH)-1:0]        out_ch,
    output logic [NUM_CH-1:0]                overrun,
    input  logic [NUM_CH-1:0]                overrun_clr
);

    localparam int CH_W = $clog2(NUM_CH);

    arb_state_t                state;
    arb_state_t                state_next;
    logic [NUM_CH-1:0]         pending;
    logic [NUM_CH-1:0]         take;
    logic [DATA_BIT_COUNT-1:0] hold [NUM_CH];
    logic [CH_W-1:0]           last_grant;
    logic [CH_W-1:0]           grant_idx;
    logic [CH_W:0]             search;
    logic                      grant_any;
    logic                      load;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rx_capture #(
            .DATA_BIT_COUNT(DATA_BIT_COUNT)
        ) u_capture (
            .clk        (clk),
            .rst        (rst),
            .rx_ready   (rx_ready[i]),
            .rx_data    (rx_data[i*DATA_BIT_COUNT +: DATA_BIT_COUNT]),
            .take       (take[i]),
            .pending    (pending[i]),
            .hold       (hold[i]),
            .overrun    (overrun[i]),
            .overrun_clr(overrun_clr[i])
        );
    end

    // Walk offsets from farthest to nearest so the channel right after last_grant wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        search    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            search = {1'b0, last_grant} + (CH_W+1)'(k);
            if (search >= (CH_W+1)'(NUM_CH)) begin
                search = search - (CH_W+1)'(NUM_CH);
            end
            if (pending[search[CH_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = search[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        take       = '0;
        case (state)
            ARB_IDLE: begin
                if (grant_any) begin
                    load       = 1'b1;
                    take       = NUM_CH'(1) << grant_idx;
                    state_next = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                if (out_ready) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            state <= state_next;
            if (load) begin
                out_data <= hold[grant_idx];
                out_ch   <= grant_idx;
            end
            if (state == ARB_OFFER && out_ready) begin
                last_grant <= out_ch;
            end
        end
    end

    assign out_valid = (state == ARB_OFFER);

endmodule
